wb_ctrl: RTL

//  Writeback sequencer for the single register-file write port.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_timeout_cnt.sv | 31 +++
 rtl/wb_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback sequencer.
package wb_pkg;

  // Writeback mux select encodings (2'd3 also decodes to pc+4 in the mux).
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    ERR
  } wb_state_t;

  // Link results win over load results: jal/jalr never wait on memory.
  function automatic logic [1:0] wb_sel_f(input logic is_link, input logic is_load);
    if (is_link) begin
      return WB_SEL_PC4;
    end else if (is_load) begin
      return WB_SEL_MEM;
    end
    return WB_SEL_ALU;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Load-response watchdog: counts cycles spent waiting and flags expiry.
// Only instantiated when WB_TIMEOUT_EN is defined.
module wb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_cnt;

  // Expiry on the last waiting cycle, so the error state lands after exactly
  // TIMEOUT_CYCLES cycles of waiting.
  assign o_expired = i_run && (r_cnt == LastCnt);

  // Wait-cycle counter, cleared on entry to the waiting state.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_cnt <= '0;
    end else if (i_run && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// Writeback sequencer for the single register-file write port.
// Drives the registered writeback mux select and issues rf write enable/address one
// cycle later, matching the mux's own output register. Loads are held until the
// data-memory response arrives.
// Optional feature macro: WB_TIMEOUT_EN (load-response watchdog with sticky wb_err).
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned RA_W           = 5,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_reg_write,
  input  logic            ex_is_load,
  input  logic            ex_is_link,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            mem_rsp_valid,
  output logic [1:0]      wb_sel,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic            load_pending,
  output logic            wb_err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  wb_state_t       r_state;
  // Slot aligned with wb_sel: becomes rf_we/rf_waddr one edge later.
  logic            r_p1_we;
  logic [RA_W-1:0] r_p1_rd;
  // Destination of the outstanding load.
  logic            r_ld_we;
  logic [RA_W-1:0] r_ld_rd;

  logic            w_accept;
  logic            w_we;
  logic            w_load;
  logic            w_expired;

  assign ex_ready = (r_state == IDLE);
  assign w_accept = ex_valid && ex_ready;
  // Writes to x0 or non-writing instructions sequence normally but never write.
  assign w_we     = ex_reg_write && (ex_rd != '0);
  assign w_load   = ex_is_load && !ex_is_link;

`ifdef WB_TIMEOUT_EN
  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_accept && w_load),
    .i_run    (r_state == LOAD_WAIT),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
  assign wb_err    = 1'b0;
`endif

  // Sequencer FSM with registered mux select and write-port outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      wb_sel       <= WB_SEL_ALU;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      load_pending <= 1'b0;
      r_p1_we      <= 1'b0;
      r_p1_rd      <= '0;
      r_ld_we      <= 1'b0;
      r_ld_rd      <= '0;
`ifdef WB_TIMEOUT_EN
      wb_err       <= 1'b0;
`endif
    end else begin
      // Write port trails the select slot by one edge.
      rf_we    <= r_p1_we;
      rf_waddr <= r_p1_rd;
      r_p1_we  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            wb_sel <= wb_sel_f(ex_is_link, ex_is_load);
            if (w_load) begin
              r_state      <= LOAD_WAIT;
              load_pending <= 1'b1;
              r_ld_we      <= w_we;
              r_ld_rd      <= ex_rd;
            end else begin
              r_p1_we <= w_we;
              r_p1_rd <= ex_rd;
            end
          end
        end
        LOAD_WAIT: begin
          // A response in the expiring cycle still completes the load.
          if (mem_rsp_valid) begin
            r_state      <= IDLE;
            load_pending <= 1'b0;
            r_p1_we      <= r_ld_we;
            r_p1_rd      <= r_ld_rd;
          end else if (w_expired) begin
            r_state      <= ERR;
            load_pending <= 1'b0;
`ifdef WB_TIMEOUT_EN
            wb_err       <= 1'b1;
`endif
          end
        end
        ERR: begin
          rf_we <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
